button_debounce_edge: RTL and testbench

- Front-end conditioner for the left/right player buttons.
- Synchronizes the raw asynchronous pad inputs and debounces them with a per-channel counter FSM.
- Emits one-cycle press pulses on o_left_debounced/o_right_debounced; these drive the ship position logic, which moves one column per pulse.
- Also exports clean held levels for other game logic.

---
 rtl/button_debounce_edge_if.sv | 18 +
 rtl/button_debounce_edge.sv | 108 ++++++++++
 tb/tb_button_debounce_edge.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/button_debounce_edge_if.sv
// button_debounce_edge_if: raw pad inputs, enable and conditioned outputs of the button front end.
interface button_debounce_edge_if;
    logic i_left_raw;
    logic i_right_raw;
    logic i_enable;
    logic o_left_debounced;
    logic o_right_debounced;
    logic o_left_level;
    logic o_right_level;
    modport master (
        output i_left_raw, i_right_raw, i_enable,
        input  o_left_debounced, o_right_debounced, o_left_level, o_right_level
    );
    modport slave (
        input  i_left_raw, i_right_raw, i_enable,
        output o_left_debounced, o_right_debounced, o_left_level, o_right_level
    );
endinterface

// File: rtl/button_debounce_edge.sv
// button_debounce_edge: synchronize, debounce and edge-detect the left/right buttons.
// Define BUTTON_AUTOREPEAT_EN to add held-button auto-repeat pulses.
module button_debounce_edge #(
    parameter int DEBOUNCE_CYCLES = 360000,
    parameter int ACTIVE_LOW      = 1,
    parameter int REPEAT_DELAY    = 18000000,
    parameter int REPEAT_PERIOD   = 3600000
) (
    input logic i_clk_36MHz,
    input logic i_reset,
    button_debounce_edge_if.slave bus
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic POL = (ACTIVE_LOW != 0);
    typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_e;
    if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
        $error("button_debounce_edge: illegal parameter value");
    end
    logic [1:0] raw, sync1_q, sync2_q, press, level, pulse_q, pulse_d;
    assign raw = {bus.i_right_raw, bus.i_left_raw} ^ {2{POL}};
    for (genvar c = 0; c < 2; c++) begin : g_ch
        state_e state_q, state_d;
        logic [CW-1:0] cnt_q, cnt_d;
        logic level_q, level_d, fire;
        logic s;
        assign s = sync2_q[c];
        always_comb begin
            state_d = state_q;
            cnt_d = cnt_q;
            fire = 1'b0;
            case (state_q)
                IDLE: if (s) begin
                    state_d = PRESS_WAIT;
                    cnt_d = CW'(1);
                end
                PRESS_WAIT: if (!s) begin
                    state_d = IDLE;
                    cnt_d = '0;
                end else if (cnt_q == CW'(DEBOUNCE_CYCLES)) begin
                    state_d = HELD;
                    cnt_d = '0;
                    fire = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
                HELD: if (!s) begin
                    state_d = RELEASE_WAIT;
                    cnt_d = CW'(1);
                end
                default: if (s) begin
                    state_d = HELD;
                    cnt_d = '0;
                end else if (cnt_q == CW'(DEBOUNCE_CYCLES)) begin
                    state_d = IDLE;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            endcase
            level_d = (state_d == HELD) || (state_d == RELEASE_WAIT);
        end
        always_ff @(posedge i_clk_36MHz) begin
            state_q <= i_reset ? IDLE : state_d;
            cnt_q   <= i_reset ? '0 : cnt_d;
            level_q <= i_reset ? 1'b0 : level_d;
        end
`ifdef BUTTON_AUTOREPEAT_EN
        localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
        localparam int RW = $clog2(RMAX + 1);
        logic [RW-1:0] rep_q, rep_d, rep_inc;
        logic first_q, first_d, rep_fire;
        // Counts only while HELD persists; RELEASE_WAIT holds it, returning to IDLE clears it.
        always_comb begin
            rep_d = rep_q;
            first_d = first_q;
            rep_fire = 1'b0;
            rep_inc = rep_q + 1'b1;
            if (state_d == IDLE || state_d == PRESS_WAIT) begin
                rep_d = '0;
                first_d = 1'b1;
            end else if (state_q == HELD && state_d == HELD) begin
                rep_fire = (rep_inc == (first_q ? RW'(REPEAT_DELAY) : RW'(REPEAT_PERIOD)));
                rep_d = rep_fire ? '0 : rep_inc;
                first_d = first_q && !rep_fire;
            end
        end
        always_ff @(posedge i_clk_36MHz) begin
            rep_q   <= i_reset ? '0 : rep_d;
            first_q <= i_reset ? 1'b1 : first_d;
        end
        assign press[c] = fire | rep_fire;
`else
        assign press[c] = fire;
`endif
        assign level[c] = level_q;
    end
    // Simultaneous left+right presses cancel so the ship never sees both directions at once.
    assign pulse_d = (bus.i_enable && !(&press)) ? press : 2'b00;
    always_ff @(posedge i_clk_36MHz) begin
        sync1_q <= i_reset ? 2'b00 : raw;
        sync2_q <= i_reset ? 2'b00 : sync1_q;
        pulse_q <= i_reset ? 2'b00 : pulse_d;
    end
    assign bus.o_left_debounced  = pulse_q[0];
    assign bus.o_right_debounced = pulse_q[1];
    assign bus.o_left_level      = level[0];
    assign bus.o_right_level     = level[1];
endmodule

// File: tb/tb_button_debounce_edge.sv
// tb_button_debounce_edge: directed self-checking bench, DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8.
module tb_button_debounce_edge;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;
    logic [99:0] lp, rp, ll, rl;
    int lcnt, rcnt, lfirst, rfirst;

    button_debounce_edge_if bus();
    button_debounce_edge #(
        .DEBOUNCE_CYCLES(4), .ACTIVE_LOW(1), .REPEAT_DELAY(20), .REPEAT_PERIOD(8)
    ) dut (
        .i_clk_36MHz(clk), .i_reset(rst), .bus(bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    // Index i holds outputs sampled just after the i-th edge following the call (index 0 = first edge).
    task automatic run(input int n);
        lcnt = 0; rcnt = 0; lfirst = -1; rfirst = -1;
        lp = '0; rp = '0; ll = '0; rl = '0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            lp[i] = bus.o_left_debounced;
            rp[i] = bus.o_right_debounced;
            ll[i] = bus.o_left_level;
            rl[i] = bus.o_right_level;
            if (lp[i]) begin if (lfirst < 0) lfirst = i; lcnt++; end
            if (rp[i]) begin if (rfirst < 0) rfirst = i; rcnt++; end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.i_left_raw = 1'b1; bus.i_right_raw = 1'b1; bus.i_enable = 1'b1;
        run(3);
        checks++;
        if ({lp[2], rp[2], ll[2], rl[2]} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_outputs: got %b expected 0000", {lp[2], rp[2], ll[2], rl[2]});
        end
        rst = 1'b0;
        run(50);
        checks++;
        if (lcnt + rcnt != 0 || ll[49:0] != '0 || rl[49:0] != '0) begin
            failures++;
            $display("FAIL reset_idle: pulses=%0d levels l=%h r=%h expected none", lcnt + rcnt, ll[49:0], rl[49:0]);
        end
    endtask

    task automatic test_clean_press;
        bus.i_left_raw = 1'b0;
        run(12);
        checks++;
        if (lcnt != 1 || lfirst != 6) begin
            failures++;
            $display("FAIL press_pulse: count=%0d first=%0d expected count=1 first=6", lcnt, lfirst);
        end
        checks++;
        if ({ll[5], ll[6], ll[11]} !== 3'b011) begin
            failures++;
            $display("FAIL press_level: l5,l6,l11=%b expected 011", {ll[5], ll[6], ll[11]});
        end
        bus.i_left_raw = 1'b1;
        run(10);
        checks++;
        if ({ll[5], ll[6]} !== 2'b10 || lcnt != 0) begin
            failures++;
            $display("FAIL release: l5,l6=%b pulses=%0d expected 10 and 0", {ll[5], ll[6]}, lcnt);
        end
    endtask

    task automatic test_bounce;
        logic [4:0] seq;
        seq = 5'b01010;
        for (int i = 0; i < 5; i++) begin
            bus.i_left_raw = seq[i];
            @(posedge clk);
            #1;
        end
        run(12);
        checks++;
        if (lcnt != 1 || lfirst != 5) begin
            failures++;
            $display("FAIL bounce_pulse: count=%0d first=%0d expected count=1 first=5", lcnt, lfirst);
        end
        bus.i_left_raw = 1'b1;
        run(10);
        bus.i_left_raw = 1'b0;
        run(3);
        checks++;
        if (lcnt != 0 || ll[2:0] != '0) begin
            failures++;
            $display("FAIL glitch_early: pulses=%0d level=%b expected 0 and 000", lcnt, ll[2:0]);
        end
        bus.i_left_raw = 1'b1;
        run(12);
        checks++;
        if (lcnt != 0 || ll[11:0] != '0) begin
            failures++;
            $display("FAIL glitch_late: pulses=%0d level=%h expected 0 and 000", lcnt, ll[11:0]);
        end
    endtask

    task automatic test_simultaneous;
        bus.i_left_raw = 1'b0; bus.i_right_raw = 1'b0;
        run(10);
        checks++;
        if (lcnt + rcnt != 0) begin
            failures++;
            $display("FAIL simul_suppress: left=%0d right=%0d pulses expected 0", lcnt, rcnt);
        end
        checks++;
        if ({ll[5], rl[5], ll[6], rl[6]} !== 4'b0011) begin
            failures++;
            $display("FAIL simul_level: got %b expected 0011", {ll[5], rl[5], ll[6], rl[6]});
        end
        bus.i_left_raw = 1'b1; bus.i_right_raw = 1'b1;
        run(10);
        bus.i_left_raw = 1'b0;
        run(2);
        bus.i_right_raw = 1'b0;
        run(10);
        checks++;
        if (lcnt != 1 || lfirst != 4 || rcnt != 1 || rfirst != 6) begin
            failures++;
            $display("FAIL staggered: left %0d@%0d right %0d@%0d expected 1@4 1@6", lcnt, lfirst, rcnt, rfirst);
        end
        bus.i_left_raw = 1'b1; bus.i_right_raw = 1'b1;
        run(10);
    endtask

    task automatic test_enable;
        bus.i_enable = 1'b0;
        bus.i_left_raw = 1'b0;
        run(10);
        checks++;
        if (lcnt != 0 || ll[9] !== 1'b1) begin
            failures++;
            $display("FAIL enable_mask: pulses=%0d level=%b expected 0 and 1", lcnt, ll[9]);
        end
        bus.i_enable = 1'b1;
        run(10);
        checks++;
        if (lcnt != 0 || ll[9] !== 1'b1) begin
            failures++;
            $display("FAIL enable_reenable: pulses=%0d level=%b expected 0 and 1", lcnt, ll[9]);
        end
        bus.i_left_raw = 1'b1;
        run(10);
    endtask

    task automatic test_reset_mid;
        bus.i_right_raw = 1'b0;
        run(4);
        rst = 1'b1;
        run(1);
        checks++;
        if ({rp[0], rl[0]} !== 2'b00) begin
            failures++;
            $display("FAIL reset_mid_outputs: got %b expected 00", {rp[0], rl[0]});
        end
        rst = 1'b0;
        run(10);
        checks++;
        if (rcnt != 1 || rfirst != 6) begin
            failures++;
            $display("FAIL reset_mid_restart: count=%0d first=%0d expected count=1 first=6", rcnt, rfirst);
        end
        bus.i_right_raw = 1'b1;
        run(10);
    endtask

    task automatic test_autorepeat;
        logic [99:0] exp_p;
        exp_p = '0;
        exp_p[6] = 1'b1;
`ifdef BUTTON_AUTOREPEAT_EN
        exp_p[26] = 1'b1; exp_p[34] = 1'b1; exp_p[42] = 1'b1;
        exp_p[50] = 1'b1; exp_p[58] = 1'b1; exp_p[66] = 1'b1;
`endif
        bus.i_left_raw = 1'b0;
        run(70);
        checks++;
        if (lp[69:0] !== exp_p[69:0]) begin
            failures++;
            $display("FAIL autorepeat: pulses=%h expected %h", lp[69:0], exp_p[69:0]);
        end
        bus.i_left_raw = 1'b1;
        run(10);
        checks++;
        if (ll[9] !== 1'b0 || lcnt != 0) begin
            failures++;
            $display("FAIL autorepeat_release: level=%b pulses=%0d expected 0 and 0", ll[9], lcnt);
        end
    endtask

    initial begin
        bus.i_left_raw = 1'b1;
        bus.i_right_raw = 1'b1;
        bus.i_enable = 1'b1;
        test_reset;
        test_clean_press;
        test_bounce;
        test_simultaneous;
        test_enable;
        test_reset_mid;
        test_autorepeat;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
